// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Two-requester round-robin write arbiter in front of an 8x16 register file.
// Grants are combinational from Valid/Stall/Last_Grant; the winning write is
// registered into a one-cycle output stage (Write_En/Write_Addr/Write_Data),
// with a per-register Busy vector and a wrapping issued-write counter.
//
// Optional feature: define REGFILE_ARB_R0_ZERO_EN to make register 0
// hardwired-zero. Transfers to address 0 are still accepted and still move
// Last_Grant, but they never raise Write_En, never count, and never set Busy[0].
module regfile_write_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Stall,
    input  logic        A_Valid,
    input  logic [2:0]  A_Addr,
    input  logic [15:0] A_Data,
    output logic        A_Ready,
    input  logic        B_Valid,
    input  logic [2:0]  B_Addr,
    input  logic [15:0] B_Data,
    output logic        B_Ready,
    output logic        Write_En,
    output logic [2:0]  Write_Addr,
    output logic [15:0] Write_Data,
    output logic [7:0]  Busy,
    output logic        Last_Grant,
    output logic [15:0] Write_Count
);

    // One-hot decode of a register address into its Busy bit.
    function automatic logic [7:0] addr_onehot(input logic [2:0] addr);
        logic [7:0] onehot;
        onehot = 8'd0;
        case (addr)
            3'd0:    onehot = 8'h01;
            3'd1:    onehot = 8'h02;
            3'd2:    onehot = 8'h04;
            3'd3:    onehot = 8'h08;
            3'd4:    onehot = 8'h10;
            3'd5:    onehot = 8'h20;
            3'd6:    onehot = 8'h40;
            3'd7:    onehot = 8'h80;
            default: onehot = 8'h00;
        endcase
        return onehot;
    endfunction

    logic        a_grant_s;
    logic        b_grant_s;
    logic        grant_s;
    logic        issue_s;
    logic [2:0]  win_addr_s;
    logic [15:0] win_data_s;
    logic [7:0]  next_busy_s;

    logic        write_en_r;
    logic [2:0]  write_addr_r;
    logic [15:0] write_data_r;
    logic [7:0]  busy_r;
    logic        last_grant_r;
    logic [15:0] write_count_r;

    // Round-robin grant: reset and Stall suppress everything; under contention the requester not named by last_grant_r wins.
    always_comb begin
        a_grant_s = 1'b0;
        b_grant_s = 1'b0;
        if (!rst_n || Stall) begin
            a_grant_s = 1'b0;
            b_grant_s = 1'b0;
        end else if (A_Valid && B_Valid) begin
            a_grant_s = last_grant_r;
            b_grant_s = ~last_grant_r;
        end else begin
            a_grant_s = A_Valid;
            b_grant_s = B_Valid;
        end
    end

    // Select the winning request and decide whether it actually issues a register-file write.
    always_comb begin
        grant_s     = a_grant_s | b_grant_s;
        win_addr_s  = A_Addr;
        win_data_s  = A_Data;
        issue_s     = 1'b0;
        next_busy_s = 8'd0;
        if (b_grant_s) begin
            win_addr_s = B_Addr;
            win_data_s = B_Data;
        end else begin
            win_addr_s = A_Addr;
            win_data_s = A_Data;
        end
`ifdef REGFILE_ARB_R0_ZERO_EN
        // Register 0 reads as zero, so a write to it is accepted but dropped.
        issue_s = grant_s && (win_addr_s != 3'd0);
`else
        issue_s = grant_s;
`endif
        if (issue_s) begin
            next_busy_s = addr_onehot(win_addr_s);
        end else begin
            next_busy_s = 8'd0;
        end
    end

    // Output stage: write enable and Busy follow the current issue; address/data hold when nothing is granted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            write_en_r   <= 1'b0;
            write_addr_r <= 3'd0;
            write_data_r <= 16'd0;
            busy_r       <= 8'd0;
        end else begin
            write_en_r <= issue_s;
            busy_r     <= next_busy_s;
            if (grant_s) begin
                write_addr_r <= win_addr_s;
                write_data_r <= win_data_s;
            end else begin
                write_addr_r <= write_addr_r;
                write_data_r <= write_data_r;
            end
        end
    end

    // Arbitration history: remember who won the latest grant (reset favours A on first contention).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_r <= 1'b1;
        end else if (grant_s) begin
            last_grant_r <= b_grant_s;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

    // Issued-write counter, wrapping naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            write_count_r <= 16'd0;
        end else if (issue_s) begin
            write_count_r <= write_count_r + 16'd1;
        end else begin
            write_count_r <= write_count_r;
        end
    end

    assign A_Ready     = a_grant_s;
    assign B_Ready     = b_grant_s;
    assign Write_En    = write_en_r;
    assign Write_Addr  = write_addr_r;
    assign Write_Data  = write_data_r;
    assign Busy        = busy_r;
    assign Last_Grant  = last_grant_r;
    assign Write_Count = write_count_r;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter
// Directed plus randomized stimulus against a behavioural model of the
// arbiter's rules. A small register-file array driven by the DUT's write port
// stands in for the downstream 8x16 register file.
module tb_regfile_write_arbiter;

    logic        clk;
    logic        rst_n;
    logic        Stall;
    logic        A_Valid;
    logic [2:0]  A_Addr;
    logic [15:0] A_Data;
    logic        A_Ready;
    logic        B_Valid;
    logic [2:0]  B_Addr;
    logic [15:0] B_Data;
    logic        B_Ready;
    logic        Write_En;
    logic [2:0]  Write_Addr;
    logic [15:0] Write_Data;
    logic [7:0]  Busy;
    logic        Last_Grant;
    logic [15:0] Write_Count;

    regfile_write_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Stall      (Stall),
        .A_Valid    (A_Valid),
        .A_Addr     (A_Addr),
        .A_Data     (A_Data),
        .A_Ready    (A_Ready),
        .B_Valid    (B_Valid),
        .B_Addr     (B_Addr),
        .B_Data     (B_Data),
        .B_Ready    (B_Ready),
        .Write_En   (Write_En),
        .Write_Addr (Write_Addr),
        .Write_Data (Write_Data),
        .Busy       (Busy),
        .Last_Grant (Last_Grant),
        .Write_Count(Write_Count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream register file: commits whatever the output stage presents.
    logic [15:0] rf [8];
    always @(posedge clk) begin
        if (Write_En) rf[Write_Addr] <= Write_Data;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    logic        m_lg    = 1'b1;
    logic        m_en    = 1'b0;
    logic [2:0]  m_addr  = 3'd0;
    logic [15:0] m_data  = 16'd0;
    int unsigned m_count = 0;

    // Ready values seen mid-cycle in the most recent step
    logic obs_ar;
    logic obs_br;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: apply inputs, check Ready mid-cycle, clock, check the output stage.
    task automatic cycle(input logic rn, input logic st,
                         input logic av, input logic [2:0] aa, input logic [15:0] ad,
                         input logic bv, input logic [2:0] ba, input logic [15:0] bd,
                         input bit do_chk);
        int winner; // -1 none, 0 A, 1 B
        logic [2:0]  w_addr;
        logic [15:0] w_data;
        logic        drop;
        rst_n = rn; Stall = st;
        A_Valid = av; A_Addr = aa; A_Data = ad;
        B_Valid = bv; B_Addr = ba; B_Data = bd;

        if (!rn || st)     winner = -1;
        else if (av && bv) winner = m_lg ? 0 : 1;
        else if (av)       winner = 0;
        else if (bv)       winner = 1;
        else               winner = -1;

        @(negedge clk);
        obs_ar = A_Ready;
        obs_br = B_Ready;
        if (do_chk) begin
            chk("a_ready", {15'd0, A_Ready}, {15'd0, (winner == 0)});
            chk("b_ready", {15'd0, B_Ready}, {15'd0, (winner == 1)});
        end

        @(posedge clk);
        #1;
        if (!rn) begin
            m_lg = 1'b1; m_en = 1'b0; m_addr = 3'd0; m_data = 16'd0; m_count = 0;
        end else if (winner >= 0) begin
            w_addr = (winner == 1) ? ba : aa;
            w_data = (winner == 1) ? bd : ad;
            m_lg   = (winner == 1);
            m_addr = w_addr;
            m_data = w_data;
`ifdef REGFILE_ARB_R0_ZERO_EN
            drop = (w_addr == 3'd0);
`else
            drop = 1'b0;
`endif
            m_en = !drop;
            if (!drop) m_count = (m_count + 1) % 65536;
        end else begin
            m_en = 1'b0;
        end

        if (do_chk) begin
            chk("write_en",    {15'd0, Write_En},   {15'd0, m_en});
            chk("write_addr",  {13'd0, Write_Addr}, {13'd0, m_addr});
            chk("write_data",  Write_Data,          m_data);
            chk("busy",        {8'd0, Busy},        m_en ? (16'd1 << m_addr) : 16'd0);
            chk("last_grant",  {15'd0, Last_Grant}, {15'd0, m_lg});
            chk("write_count", Write_Count,         m_count[15:0]);
        end
    endtask

    task automatic idle(input bit do_chk);
        cycle(1'b1, 1'b0, 1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0, do_chk);
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b0, 1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0, 1'b1);
    endtask

    initial begin
        logic [2:0] exp_seq [4];
        logic       lg_before;
        rst_n = 1'b0; Stall = 1'b0;
        A_Valid = 1'b0; A_Addr = 3'd0; A_Data = 16'd0;
        B_Valid = 1'b0; B_Addr = 3'd0; B_Data = 16'd0;
        @(posedge clk);
        #1;

        // Reset state
        do_reset();
        chk("rst_write_en",   {15'd0, Write_En},   16'd0);
        chk("rst_busy",       {8'd0, Busy},        16'd0);
        chk("rst_last_grant", {15'd0, Last_Grant}, 16'd1);
        chk("rst_count",      Write_Count,         16'd0);

        // Single write from A
        cycle(1'b1, 1'b0, 1'b1, 3'd3, 16'h0078, 1'b0, 3'd0, 16'd0, 1'b1);
        chk("s1_a_ready",  {15'd0, obs_ar},      16'd1);
        chk("s1_en",       {15'd0, Write_En},    16'd1);
        chk("s1_addr",     {13'd0, Write_Addr},  16'd3);
        chk("s1_data",     Write_Data,           16'h0078);
        chk("s1_busy",     {8'd0, Busy},         16'h0008);
        chk("s1_count",    Write_Count,          16'd1);
        idle(1'b1);

        // Sustained contention alternates A,B,A,B
        do_reset();
        exp_seq[0] = 3'd1; exp_seq[1] = 3'd2; exp_seq[2] = 3'd1; exp_seq[3] = 3'd2;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, 1'b1, 3'd1, 16'h1000 + 16'(i), 1'b1, 3'd2, 16'h2000 + 16'(i), 1'b1);
            chk("rr_a_ready", {15'd0, obs_ar},     {15'd0, (i % 2 == 0)});
            chk("rr_addr",    {13'd0, Write_Addr}, {13'd0, exp_seq[i]});
        end
        chk("rr_count", Write_Count, 16'd4);
        idle(1'b1);

        // Same-address collision: A then B, second write wins in the register file
        cycle(1'b1, 1'b0, 1'b1, 3'd5, 16'h00BC, 1'b1, 3'd5, 16'h00DE, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 3'd5, 16'h00BC, 1'b1, 3'd5, 16'h00DE, 1'b1);
        chk("coll_rf5_mid", rf[5], 16'h00BC);
        idle(1'b1);
        chk("coll_rf5_final", rf[5], 16'h00DE);

        // Stall blocks both requesters; release grants the one not named by Last_Grant
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1, 1'b1, 3'd6, 16'h0606, 1'b1, 3'd7, 16'h0707, 1'b1);
            chk("stall_ready", {14'd0, obs_ar, obs_br}, 16'd0);
            chk("stall_en",    {15'd0, Write_En},       16'd0);
        end
        lg_before = m_lg;
        cycle(1'b1, 1'b0, 1'b1, 3'd6, 16'h0606, 1'b1, 3'd7, 16'h0707, 1'b1);
        chk("unstall_a_ready", {15'd0, obs_ar}, {15'd0, lg_before});
        chk("unstall_b_ready", {15'd0, obs_br}, {15'd0, ~lg_before});

        // Reset while the output stage holds a write; transfer in the reset cycle is discarded
        cycle(1'b1, 1'b0, 1'b1, 3'd4, 16'h4444, 1'b0, 3'd0, 16'd0, 1'b1);
        chk("pre_rst_en", {15'd0, Write_En}, 16'd1);
        cycle(1'b0, 1'b0, 1'b1, 3'd4, 16'h5555, 1'b1, 3'd2, 16'h6666, 1'b1);
        chk("rst_cycle_ready", {14'd0, obs_ar, obs_br}, 16'd0);
        chk("rst_cancel_en",   {15'd0, Write_En},       16'd0);
        chk("rst_cancel_busy", {8'd0, Busy},            16'd0);
        chk("rst_cancel_cnt",  Write_Count,             16'd0);
        idle(1'b1);

        // Randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            cycle(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) == 0),
                  1'($urandom), 3'($urandom), 16'($urandom),
                  1'($urandom), 3'($urandom), 16'($urandom), 1'b1);
        end

`ifdef REGFILE_ARB_R0_ZERO_EN
        // Hardwired-zero register 0
        do_reset();
        cycle(1'b1, 1'b0, 1'b1, 3'd2, 16'h1234, 1'b0, 3'd0, 16'd0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 3'd0, 16'd0, 1'b1, 3'd0, 16'hABCD, 1'b1);
        chk("r0_b_ready", {15'd0, obs_br},     16'd1);
        chk("r0_en",      {15'd0, Write_En},   16'd0);
        chk("r0_busy",    {8'd0, Busy},        16'd0);
        chk("r0_lg",      {15'd0, Last_Grant}, 16'd1);
        chk("r0_count",   Write_Count,         16'd1);
`endif

        // Counter wrap: 65535 writes, then one more
        do_reset();
        for (int i = 0; i < 65535; i++) begin
            cycle(1'b1, 1'b0, 1'b1, 3'd3, 16'(i), 1'b0, 3'd0, 16'd0, 1'b0);
        end
        chk("wrap_preload", Write_Count, 16'hFFFF);
        cycle(1'b1, 1'b0, 1'b1, 3'd6, 16'hCAFE, 1'b0, 3'd0, 16'd0, 1'b1);
        chk("wrap_zero", Write_Count, 16'h0000);
        idle(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
